// File: rtl/mult_pkg.sv
// Shared widths and types for the 4x4 multiplier and its frame accumulator.
//   MULT_IN_W   : multiplier operand width
//   MULT_PROD_W : multiplier product width (feeds mult_accum.in_prod)
//   MACC_W      : default accumulator / result width
//   MCNT_W      : default beat-counter width
package mult_pkg;

   localparam int MULT_IN_W   = 4;
   localparam int MULT_PROD_W = 8;
   localparam int MACC_W      = 12;
   localparam int MCNT_W      = 5;

   // Result buffer occupancy: EMPTY <=> out_valid=0, FULL <=> out_valid=1.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   // One per-frame result record at the default widths.
   typedef struct packed {
      logic [MACC_W-1:0] sum;
      logic [MCNT_W-1:0] cnt;
      logic              ovf;
   } mult_res_t;

endpackage

// File: rtl/mult_accum_acc_add.sv
// acc_add: unsigned (ACC_W)+(PW) -> (ACC_W+1) parallel-prefix adder.
//   a_i   : ACC_W-bit addend (running accumulator)
//   b_i   : PW-bit addend, zero-extended to ACC_W
//   sum_o : {carry-out, ACC_W-bit sum}
// Kogge-Stone style prefix tree: each level combines (g,p) pairs at span d
// (BLACK cells); positions below d already hold their final group generate
// and only pass through (GREY/terminal positions).
module acc_add #(
   parameter int ACC_W = 12,
   parameter int PW    = 8
) (
   input  logic [ACC_W-1:0] a_i,
   input  logic [PW-1:0]    b_i,
   output logic [ACC_W:0]   sum_o
);

   logic [ACC_W-1:0] bx;
   logic [ACC_W-1:0] p0;
   logic [ACC_W-1:0] g;
   logic [ACC_W-1:0] p;
   logic [ACC_W-1:0] carry;

   always_comb begin
      bx = ACC_W'(b_i);
      p0 = a_i ^ bx;
      g  = a_i & bx;
      p  = p0;
      for (int unsigned d = 1; d < ACC_W; d = d * 2) begin
         // Vectorised prefix level: bit i combines with bit i-d; bits below d
         // see zeros from the shift and keep their value.
         g = g | (p & (g << d));
         p = p & ((p << d) | ~({ACC_W{1'b1}} << d));
      end
      // Carry into bit i is the group generate of bits [i-1:0].
      carry = g << 1;
      sum_o = {g[ACC_W-1], p0 ^ carry};
   end

endmodule

// File: rtl/mult_accum.sv
// mult_accum: sums framed unsigned products into a wide accumulator and
// presents one {sum, beat count, overflow} result per frame.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : product beat handshake (in_ready = !out_valid | out_ready)
//   in_prod, in_last    : product value, final-beat marker
//   out_valid/out_ready : buffered frame-result handshake
//   out_sum             : frame sum modulo 2^ACC_W
//   out_cnt             : beats in frame, saturating at 2^CNT_W-1
//   out_ovf             : sum carried out of ACC_W bits at some point in frame
module mult_accum
   import mult_pkg::*;
#(
   parameter int PW    = MULT_PROD_W,
   parameter int ACC_W = MACC_W,
   parameter int CNT_W = MCNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PW-1:0]    in_prod,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   buf_state_t       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] rsum_q, rsum_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic             rovf_q, rovf_d;

   logic [ACC_W:0]   add_w;
   logic [ACC_W-1:0] nsum;
   logic [CNT_W-1:0] ncnt;
   logic             nov;
   logic             in_fire;
   logic             out_fire;
   logic             last_fire;

   acc_add #(
      .ACC_W (ACC_W),
      .PW    (PW)
   ) u_add (
      .a_i   (acc_q),
      .b_i   (in_prod),
      .sum_o (add_w)
   );

   assign out_valid = (state_q == FULL);
   // Combinational out_ready -> in_ready path lets a pop and a push share a cycle.
   assign in_ready  = !out_valid | out_ready;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign last_fire = in_fire & in_last;

   assign nsum = add_w[ACC_W-1:0];
   assign nov  = ovf_q | add_w[ACC_W];
   assign ncnt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   assign out_sum = rsum_q;
   assign out_cnt = rcnt_q;
   assign out_ovf = rovf_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      rsum_d  = rsum_q;
      rcnt_d  = rcnt_q;
      rovf_d  = rovf_q;

      case (state_q)
         EMPTY:   if (last_fire) state_d = FULL;
         FULL:    if (out_fire && !last_fire) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase

      if (in_fire) begin
         if (in_last) begin
            rsum_d = nsum;
            rcnt_d = ncnt;
            rovf_d = nov;
            acc_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
         end else begin
            acc_d  = nsum;
            cnt_d  = ncnt;
            ovf_d  = nov;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         rsum_q  <= '0;
         rcnt_q  <= '0;
         rovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rsum_q  <= rsum_d;
         rcnt_q  <= rcnt_d;
         rovf_q  <= rovf_d;
      end
   end

endmodule

// File: tb/tb_mult_accum.sv
// Directed self-checking bench for mult_accum at default widths
// (PW=8, ACC_W=12, CNT_W=5).
module tb_mult_accum;
   import mult_pkg::*;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [MACC_W-1:0] out_sum;
   logic [MCNT_W-1:0] out_cnt;
   logic              out_ovf;

   int unsigned tests;
   int unsigned fails;

   mult_accum #(
      .PW    (MULT_PROD_W),
      .ACC_W (MACC_W),
      .CNT_W (MCNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cnt   (out_cnt),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic v, input mult_res_t e);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".sum"},   32'(out_sum),   32'(e.sum));
      chk({tag, ".cnt"},   32'(out_cnt),   32'(e.cnt));
      chk({tag, ".ovf"},   32'(out_ovf),   32'(e.ovf));
   endtask

   task automatic beat(input logic [7:0] prod, input logic last);
      in_valid = 1'b1;
      in_prod  = prod;
      in_last  = last;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_prod  = 8'hxx;
      tick();
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state, held across 10 idle cycles.
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("rst.in_ready", 32'(in_ready), 32'd1);
         chk_res("rst", 1'b0, '{sum: 12'd0, cnt: 5'd0, ovf: 1'b0});
      end

      // Frame 6, 225, 10 -> 241, 3 beats.
      beat(8'd6, 1'b0);
      chk("f1.mid_valid", 32'(out_valid), 32'd0);
      beat(8'd225, 1'b0);
      beat(8'd10, 1'b1);
      chk_res("f1", 1'b1, '{sum: 12'd241, cnt: 5'd3, ovf: 1'b0});
      idle();
      chk_res("f1.pop", 1'b0, '{sum: 12'd241, cnt: 5'd3, ovf: 1'b0});

      // 19 x 225 = 4275 -> wraps to 179, overflow.
      for (int i = 0; i < 19; i++) beat(8'd225, (i == 18));
      chk_res("wrap", 1'b1, '{sum: 12'd179, cnt: 5'd19, ovf: 1'b1});
      // Single-beat frame pushed in the same cycle the previous result pops.
      beat(8'd5, 1'b1);
      chk_res("single", 1'b1, '{sum: 12'd5, cnt: 5'd1, ovf: 1'b0});
      idle();
      chk("single.pop", 32'(out_valid), 32'd0);

      // Backpressure: result 100 held while 50 is offered.
      out_ready = 1'b0;
      beat(8'd100, 1'b1);
      chk_res("bp.load", 1'b1, '{sum: 12'd100, cnt: 5'd1, ovf: 1'b0});
      in_prod = 8'd50;
      in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp.in_ready", 32'(in_ready), 32'd0);
         tick();
         chk_res("bp.hold", 1'b1, '{sum: 12'd100, cnt: 5'd1, ovf: 1'b0});
      end
      out_ready = 1'b1;
      #1;
      chk("bp.release_ready", 32'(in_ready), 32'd1);
      tick();
      chk_res("bp.next", 1'b1, '{sum: 12'd50, cnt: 5'd1, ovf: 1'b0});
      idle();
      chk("bp.drain", 32'(out_valid), 32'd0);

      // Back-to-back single-beat frames 1, 2, 3.
      for (int v = 1; v <= 3; v++) begin
         beat(8'(v), 1'b1);
         chk_res("b2b", 1'b1, '{sum: 12'(v), cnt: 5'd1, ovf: 1'b0});
      end
      idle();
      chk("b2b.drain", 32'(out_valid), 32'd0);

      // 40 zero beats: count saturates at 31 with no overflow.
      for (int i = 0; i < 40; i++) beat(8'd0, (i == 39));
      chk_res("sat", 1'b1, '{sum: 12'd0, cnt: 5'd31, ovf: 1'b0});
      idle();

      // Reset on beat 3 discards the partial frame.
      beat(8'd200, 1'b0);
      beat(8'd200, 1'b0);
      rst = 1'b1;
      beat(8'd200, 1'b0);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("mrst.in_ready", 32'(in_ready), 32'd1);
      chk_res("mrst", 1'b0, '{sum: 12'd0, cnt: 5'd0, ovf: 1'b0});
      beat(8'd7, 1'b1);
      chk_res("mrst.next", 1'b1, '{sum: 12'd7, cnt: 5'd1, ovf: 1'b0});

      // Reset also discards a pending result.
      out_ready = 1'b0;
      in_valid  = 1'b0;
      rst       = 1'b1;
      tick();
      rst = 1'b0;
      chk_res("prst", 1'b0, '{sum: 12'd0, cnt: 5'd0, ovf: 1'b0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
